// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for one data-memory requester: request/payload from the
// requester, combinational grant and routed read return from the arbiter.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wen;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, addr, wdata, wen, input gnt, rvalid, rdata);
  modport slave  (input req, addr, wdata, wen, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single synchronous data-RAM port. Round-robin by
// default; define DMEM_ARB_PRIO_EN for m0 priority with an m1 starvation guard.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_arbiter_if.slave         m0,
  dmem_arbiter_if.slave         m1,
  output logic                  mem_en,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wen;
  } access_t;

  logic    gnt0, gnt1;
  logic    accept;
  access_t sel;

  // Read-return tag travels one stage behind mem_en, then becomes rvalid.
  logic    rd_pend, rd_owner;
  logic    rvalid0_q, rvalid1_q;

`ifdef DMEM_ARB_PRIO_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_m1;

  assign force_m1 = (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign gnt0     = m0.req & (~m1.req | ~force_m1);
  assign gnt1     = m1.req & (~m0.req |  force_m1);

  // Once the limit is hit a pending m1 is always granted, so the count saturates there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!m1.req || gnt1) begin
      starve_cnt <= '0;
    end else if (!force_m1) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic last;

  // On a tie the requester that did not win most recently goes next.
  assign gnt0 = m0.req & (~m1.req |  last);
  assign gnt1 = m1.req & (~m0.req | ~last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= gnt1;
    end
  end
`endif

  assign accept = gnt0 | gnt1;
  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  // NOTE: every variable assigned in always_comb gets a default first; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    sel = '{addr: m0.addr, wdata: m0.wdata, wen: m0.wen};
    if (gnt1) begin
      sel = '{addr: m1.addr, wdata: m1.wdata, wen: m1.wen};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register in
  // this block samples pre-edge values, which is what makes the pipeline stages line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_pend   <= 1'b0;
      rd_owner  <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      mem_en  <= accept;
      mem_wen <= accept & sel.wen;
      if (accept) begin
        mem_addr  <= sel.addr;
        mem_wdata <= sel.wdata;
      end
      rd_pend   <= accept & ~sel.wen;
      rd_owner  <= gnt1;
      rvalid0_q <= rd_pend & ~rd_owner;
      rvalid1_q <= rd_pend &  rd_owner;
    end
  end

  // RAM data arrives combinationally in the return cycle; gate so idle rdata reads 0.
  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.rdata  = rvalid0_q ? mem_rdata : '0;
  assign m1.rdata  = rvalid1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1-cycle-latency RAM model; covers reset,
// reads, writes, tie-break, contention and mid-stream reset (prio mode if defined).
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_if ();
  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_if ();

  logic          mem_en, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  logic [5:0] exp_g0 = 6'b010101;        // bit k: m0 wins contention cycle k
  logic [9:0] exp_p1 = 10'b10_0001_0000; // bit k: m1 wins priority cycle k

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // RAM model: fixed contents overlaid by anything written.
  logic [DW-1:0] wr_data  [0:65535];
  bit            wr_valid [0:65535];

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {16'hC0DE, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_wen) begin
      wr_data[mem_addr]  <= mem_wdata;
      wr_valid[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_wen) begin
      mem_rdata <= wr_valid[mem_addr] ? wr_data[mem_addr] : rom(mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    m0_if.req = req; m0_if.addr = a; m0_if.wdata = d; m0_if.wen = w;
  endtask

  task automatic drive_m1(input logic req, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    m1_if.req = req; m1_if.addr = a; m1_if.wdata = d; m1_if.wen = w;
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, ".mem_en"},    mem_en,       1'b0);
    check_bit({tag, ".mem_wen"},   mem_wen,      1'b0);
    check    ({tag, ".mem_addr"},  {16'b0, mem_addr}, 32'h0);
    check    ({tag, ".mem_wdata"}, mem_wdata,    32'h0);
    check_bit({tag, ".m0_rvalid"}, m0_if.rvalid, 1'b0);
    check_bit({tag, ".m1_rvalid"}, m1_if.rvalid, 1'b0);
    check    ({tag, ".m0_rdata"},  m0_if.rdata,  32'h0);
    check    ({tag, ".m1_rdata"},  m1_if.rdata,  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_m0(1'b0, '0, '0, 1'b0);
    drive_m1(1'b0, '0, '0, 1'b0);
    rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    check_bit("reset.m0_gnt_idle", m0_if.gnt, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Tie on the first cycle after reset: m0 first, m1 next.
    drive_m0(1'b1, 16'h0010, '0, 1'b0);
    drive_m1(1'b1, 16'h0011, '0, 1'b0);
    @(negedge clk);
    check_bit("tie.m0_gnt", m0_if.gnt, 1'b1);
    check_bit("tie.m1_gnt", m1_if.gnt, 1'b0);
    tick();
    drive_m0(1'b0, '0, '0, 1'b0);
    check_bit("rd0.mem_en",   mem_en,  1'b1);
    check_bit("rd0.mem_wen",  mem_wen, 1'b0);
    check    ("rd0.mem_addr", {16'b0, mem_addr}, 32'h0010);
    check_bit("rd0.m0_rvalid_early", m0_if.rvalid, 1'b0);
    @(negedge clk);
    check_bit("tie2.m1_gnt", m1_if.gnt, 1'b1);
    check_bit("tie2.m0_gnt", m0_if.gnt, 1'b0);
    tick();
    drive_m1(1'b0, '0, '0, 1'b0);
    check    ("rd1.mem_addr",  {16'b0, mem_addr}, 32'h0011);
    check_bit("rd0.m0_rvalid", m0_if.rvalid, 1'b1);
    check    ("rd0.m0_rdata",  m0_if.rdata,  32'hDEADBEEF);
    check_bit("rd0.m1_rvalid", m1_if.rvalid, 1'b0);
    tick();
    check_bit("rd1.m1_rvalid", m1_if.rvalid, 1'b1);
    check    ("rd1.m1_rdata",  m1_if.rdata,  32'hC0DE0011);
    check_bit("rd1.m0_rvalid", m0_if.rvalid, 1'b0);
    check_bit("rd1.mem_en_idle", mem_en, 1'b0);
    tick();
    check_bit("rd1.m1_rvalid_once", m1_if.rvalid, 1'b0);

    // m1 write: strobe with data, no read return.
    drive_m1(1'b1, 16'h0020, 32'h12345678, 1'b1);
    @(negedge clk);
    check_bit("wr.m1_gnt", m1_if.gnt, 1'b1);
    tick();
    drive_m1(1'b0, '0, '0, 1'b0);
    check_bit("wr.mem_en",    mem_en,  1'b1);
    check_bit("wr.mem_wen",   mem_wen, 1'b1);
    check    ("wr.mem_addr",  {16'b0, mem_addr}, 32'h0020);
    check    ("wr.mem_wdata", mem_wdata, 32'h12345678);
    tick();
    check_bit("wr.mem_en_off",  mem_en,  1'b0);
    check_bit("wr.mem_wen_off", mem_wen, 1'b0);
    check    ("wr.addr_hold",   {16'b0, mem_addr}, 32'h0020);
    check    ("wr.wdata_hold",  mem_wdata, 32'h12345678);
    check_bit("wr.m0_rvalid", m0_if.rvalid, 1'b0);
    check_bit("wr.m1_rvalid", m1_if.rvalid, 1'b0);
    tick();
    check_bit("wr.m0_rvalid2", m0_if.rvalid, 1'b0);
    check_bit("wr.m1_rvalid2", m1_if.rvalid, 1'b0);

    // m0 alone, back-to-back writes: granted every cycle.
    for (int k = 0; k < 3; k++) begin
      drive_m0(1'b1, 16'h0050 + 16'(k), 32'hA000_0000 + 32'(k), 1'b1);
      @(negedge clk);
      check_bit("b2b.m0_gnt", m0_if.gnt, 1'b1);
      tick();
      check_bit("b2b.mem_en",    mem_en, 1'b1);
      check    ("b2b.mem_addr",  {16'b0, mem_addr}, 32'h0050 + 32'(k));
      check    ("b2b.mem_wdata", mem_wdata, 32'hA000_0000 + 32'(k));
    end
    drive_m0(1'b0, '0, '0, 1'b0);

    // m1 reads back the written word.
    drive_m1(1'b1, 16'h0020, '0, 1'b0);
    tick();
    drive_m1(1'b0, '0, '0, 1'b0);
    tick();
    check_bit("rb.m1_rvalid", m1_if.rvalid, 1'b1);
    check    ("rb.m1_rdata",  m1_if.rdata,  32'h12345678);
    check_bit("rb.m0_rvalid", m0_if.rvalid, 1'b0);
    tick();

`ifndef DMEM_ARB_PRIO_EN
    // Full contention: strict alternation, returns in issue order.
    drive_m0(1'b1, 16'h0030, '0, 1'b0);
    drive_m1(1'b1, 16'h0040, '0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_bit("rr.m0_gnt", m0_if.gnt, exp_g0[k]);
      check_bit("rr.m1_gnt", m1_if.gnt, ~exp_g0[k]);
      tick();
      check("rr.mem_addr", {16'b0, mem_addr}, exp_g0[k] ? 32'h0030 : 32'h0040);
      if (k > 0) begin
        check_bit("rr.m0_rvalid", m0_if.rvalid, exp_g0[k-1]);
        check_bit("rr.m1_rvalid", m1_if.rvalid, ~exp_g0[k-1]);
        if (exp_g0[k-1]) check("rr.m0_rdata", m0_if.rdata, 32'hC0DE0030);
        else             check("rr.m1_rdata", m1_if.rdata, 32'hC0DE0040);
      end
    end
    drive_m0(1'b0, '0, '0, 1'b0);
    drive_m1(1'b0, '0, '0, 1'b0);
    tick();
    check_bit("rr.tail_m1_rvalid", m1_if.rvalid, 1'b1);
    check    ("rr.tail_m1_rdata",  m1_if.rdata,  32'hC0DE0040);
    check_bit("rr.tail_m0_rvalid", m0_if.rvalid, 1'b0);
    tick();
    check_bit("rr.end_m1_rvalid", m1_if.rvalid, 1'b0);
`endif

    // Reset with reads in flight: everything clears, pending return dropped.
    drive_m0(1'b1, 16'h0030, '0, 1'b0);
    tick();
    drive_m0(1'b0, '0, '0, 1'b0);
    drive_m1(1'b1, 16'h0040, '0, 1'b0);
    tick();
    drive_m1(1'b0, '0, '0, 1'b0);
    check_bit("mid.pre_m0_rvalid", m0_if.rvalid, 1'b1);
    check_bit("mid.pre_mem_en",    mem_en,       1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_bit("post1.m0_rvalid", m0_if.rvalid, 1'b0);
    check_bit("post1.m1_rvalid", m1_if.rvalid, 1'b0);
    check_bit("post1.mem_en",    mem_en,       1'b0);
    tick();
    check_bit("post2.m0_rvalid", m0_if.rvalid, 1'b0);
    check_bit("post2.m1_rvalid", m1_if.rvalid, 1'b0);

`ifdef DMEM_ARB_PRIO_EN
    // Priority with starvation guard: m0 x4, m1 x1, repeating.
    drive_m0(1'b1, 16'h0030, '0, 1'b0);
    drive_m1(1'b1, 16'h0040, '0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_bit("prio.m1_gnt", m1_if.gnt, exp_p1[k]);
      check_bit("prio.m0_gnt", m0_if.gnt, ~exp_p1[k]);
      tick();
    end
    drive_m0(1'b0, '0, '0, 1'b0);
    drive_m1(1'b0, '0, '0, 1'b0);
    tick();
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single data-memory port between requester 0 (CPU core load/store path) and requester 1 (DMA/debug master).
- Pipelined, one access accepted per cycle.
- Registered memory-side outputs; read data is routed back to the requester that issued the read.
- Sits between the requesters and the synchronous data RAM (1-cycle read latency).

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 16, word address width.
- STARVE_LIMIT, 4, consecutive losses by m1 before a forced grant (used only with the optional feature).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_req  input  1  requester 0 access request; held until granted.
- m0_addr  input  ADDR_WIDTH  requester 0 address.
- m0_wdata  input  DATA_WIDTH  requester 0 write data.
- m0_wen  input  1  requester 0 write (1) / read (0).
- m0_gnt  output  1  requester 0 accepted this cycle (combinational).
- m0_rvalid  output  1  read data valid for requester 0.
- m0_rdata  output  DATA_WIDTH  read data for requester 0.
- m1_req, m1_addr, m1_wdata, m1_wen, m1_gnt, m1_rvalid, m1_rdata: same as m0_* for requester 1.
- mem_en  output  1  memory access strobe (registered).
- mem_wen  output  1  memory write enable (registered).
- mem_addr  output  ADDR_WIDTH  memory address (registered).
- mem_wdata  output  DATA_WIDTH  memory write data (registered).
- mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after mem_en with mem_wen=0.

Behaviour:
- Reset (async, rst_n=0):
  - mem_en, mem_wen, mem_addr and mem_wdata are 0.
  - m0_rvalid and m1_rvalid are 0; rdata outputs are 0.
  - Round-robin pointer last=1, so m0 wins the first tie.
  - Starve counter is 0. In-flight read tags are cleared.
- Arbitration (combinational, every cycle):
  - Only m0_req: m0_gnt=1.
  - Only m1_req: m1_gnt=1.
  - Both: grant goes to the requester not equal to last.
  - Neither: no grant.
  - At most one gnt is high per cycle. gnt never asserts without the matching req.
- Accept: a transfer occurs when req&gnt at edge N.
  - Cycle N+1: mem_en=1; mem_addr/mem_wdata/mem_wen are the winner's captured values.
  - last is updated to the winner at edge N.
  - No accept in cycle N: mem_en=0 in N+1; mem_wen is forced 0; addr/wdata hold their previous values.
- Read return:
  - A 1-bit valid plus owner tag is registered alongside mem_en.
  - In cycle N+2, mem_rdata is passed to the owner's rdata, and the owner's rvalid=1 for exactly one cycle.
  - The non-owner's rvalid stays 0; its rdata may show mem_rdata.
  - Accept-to-rvalid latency is exactly 2 cycles.
  - Back-to-back reads, including alternating owners, return in issue order, one per cycle.
- Writes: no rvalid is generated. Write completion is the mem_en cycle.
- Requester protocol:
  - The requester holds req and its payload stable until gnt.
  - A requester may deassert req without being granted; no access is generated.
  - Continuous req from the same requester with no contention is granted every cycle.
- Full contention, both requesting every cycle: grants strictly alternate m0, m1, m0, ...
- Reset mid-operation: pending read returns are dropped. No rvalid asserts in the first 2 cycles after rst_n rises unless a new accept occurred.
- No internal FSM beyond the pointer, the pipeline register stage and the return tag. There is no backpressure from memory: it always accepts.

Optional Feature:
- Macro: DMEM_ARB_PRIO_EN.
- Defined:
  - m0 has strict priority on a tie.
  - A saturating counter increments each cycle m1_req=1 and m1 is not granted, and resets to 0 when m1 is granted or m1_req=0.
  - When the counter reaches STARVE_LIMIT, m1 wins the next tie and the counter clears.
  - The last pointer is unused.
- Not defined: plain round-robin as specified above. The counter logic is absent.

Test Plan:
- Reset values: assert rst_n=0 mid-stream with reads in flight -> all outputs 0 immediately; after release, no rvalid for 2 cycles with no requests.
- Single read: m0 read addr 0x0010 at cycle N, mem returns 0xDEADBEEF -> mem_en=1 and addr=0x0010 at N+1; m0_rvalid=1 with 0xDEADBEEF at N+2; m1_rvalid stays 0.
- Write: m1 write addr 0x0020 data 0x12345678 -> N+1 mem_en=1, mem_wen=1, addr/data match; no rvalid on either port.
- Contention, round-robin: both request reads for 6 cycles -> grants m0, m1, m0, m1, m0, m1; rvalid owners follow the same order, 2 cycles delayed.
- Tie after reset: both req in the first cycle -> m0_gnt=1; m1 granted on the next cycle.
- DMEM_ARB_PRIO_EN, STARVE_LIMIT=4: both request continuously -> m0 granted 4 cycles, m1 granted the 5th, then m0 for 4 more; repeats.
